// File: rtl/sram_read_ctrl.sv
// sram_read_ctrl: read sequencer for the NAND-latch SRAM array.
// Takes one row-read request and drives bit-line precharge, then the row
// read-enable with a sense strobe in the last cycle. It then captures the
// differential Q/Qn pair per bit and returns the word plus an integrity flag.
// Only one request is in flight at a time.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_valid/ready     request handshake, req_addr sampled on acceptance
//   rsp_valid/ready     response handshake carrying rsp_data and rsp_err
//   precharge           bit-line precharge enable
//   row_re              one-hot row read-enable (all zero for unmapped rows)
//   sense_en            sense-amp strobe
//   bit_q, bit_qn       differential cell outputs of the enabled row
module sram_read_ctrl #(
  parameter int unsigned ADDR_WIDTH       = 4,
  parameter int unsigned ROWS             = 16,
  parameter int unsigned DATA_WIDTH       = 8,
  parameter int unsigned PRECHARGE_CYCLES = 1,
  parameter int unsigned SENSE_CYCLES     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic                  precharge,
  output logic [ROWS-1:0]       row_re,
  output logic                  sense_en,
  input  logic [DATA_WIDTH-1:0] bit_q,
  input  logic [DATA_WIDTH-1:0] bit_qn
);

  localparam int unsigned MAX_CYC = (PRECHARGE_CYCLES > SENSE_CYCLES) ?
                                    PRECHARGE_CYCLES : SENSE_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] PC_LAST = CNT_W'(PRECHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SC_LAST = CNT_W'(SENSE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRECHARGE,
    ST_ACCESS,
    ST_RESPOND
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic [ROWS-1:0]       row_sel;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] cell_ok;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  cap_bad;

  // Row decode; addresses beyond the populated rows match nothing.
  for (genvar r = 0; r < int'(ROWS); r++) begin : g_row_dec
    assign row_sel[r] = (addr_q == ADDR_WIDTH'(r));
  end
  assign in_range = |row_sel;

  // A healthy latch drives Q and Qn to opposite values; equal values mean
  // the bit is unreadable and is reported as 0 with the error flag.
  assign cell_ok  = bit_q ^ bit_qn;
  assign cap_data = bit_q & cell_ok;
  assign cap_bad  = ~&cell_ok;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Next-state, capture and array-control decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    precharge = 1'b0;
    row_re    = '0;
    sense_en  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = '0;
          state_d = ST_PRECHARGE;
        end
      end
      ST_PRECHARGE: begin
        precharge = 1'b1;
        if (cnt_q == PC_LAST) begin
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        row_re   = row_sel;
        sense_en = (cnt_q == SC_LAST);
        if (cnt_q == SC_LAST) begin
          cnt_d   = '0;
          state_d = ST_RESPOND;
          data_d  = in_range ? cap_data : '0;
          err_d   = ~in_range | cap_bad;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Array controls and handshakes are quiet for the whole reset cycle.
    if (rst) begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      precharge = 1'b0;
      row_re    = '0;
      sense_en  = 1'b0;
    end
  end

  assign rsp_data = data_q;
  assign rsp_err  = err_q;

endmodule
